log_scale_arbiter: RTL

Frame-granular two-channel arbiter that time-shares a single `log_scale` instance between two FFT magnitude-squared streams (e.g. left/right spectra). The arbiter sits between the two FFT magnitude stages and the shared `log_scale`. It grants one whole frame (delimited by `last`) at a time, round-robin. It tags each beat with its source channel across the fixed `log_scale` latency and returns the 8-bit log result with the channel tag.

---
 rtl/log_scale_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/log_scale_arbiter.sv
// rtl/log_scale_arbiter.sv - frame-granular round-robin arbiter sharing one log_scale between two channels
// Optional frame-length checking is enabled with LOG_ARB_FRAME_CHECK_EN.
module log_scale_arbiter #(
    parameter int MAG_W     = 32,
    parameter int LS_LAT    = 2,
    parameter int FRAME_LEN = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MAG_W-1:0] s0_mag,
    input  logic             s0_valid,
    input  logic             s0_last,
    output logic             s0_ready,
    input  logic [MAG_W-1:0] s1_mag,
    input  logic             s1_valid,
    input  logic             s1_last,
    output logic             s1_ready,
    output logic [MAG_W-1:0] ls_mag_squared,
    output logic             ls_mag_valid,
    output logic             ls_mag_last,
    input  logic [7:0]       ls_log_out,
    input  logic             ls_log_valid,
    input  logic             ls_log_last,
    output logic [7:0]       m_log,
    output logic             m_valid,
    output logic             m_last,
    output logic             m_chan,
    output logic             busy,
    output logic             err_len
);

    typedef enum logic [1:0] {IDLE, RUN0, RUN1} state_t;

    state_t             state, state_nxt;
    logic               last_srv, last_srv_nxt;
    logic               xfer, xfer_chan, xfer_last, frame_end;
    logic [MAG_W-1:0]   xfer_mag;
    logic               force_last, err_set;
    logic               ls_chan;
    logic [LS_LAT-1:0]  tag_v, tag_c;

    assign xfer_chan = (state == RUN1);
    assign xfer      = ((state == RUN0) && s0_valid) || ((state == RUN1) && s1_valid);
    assign xfer_mag  = xfer_chan ? s1_mag : s0_mag;
    assign xfer_last = xfer_chan ? s1_last : s0_last;
    assign frame_end = xfer && (xfer_last || force_last);

`ifdef LOG_ARB_FRAME_CHECK_EN
    localparam int CW = $clog2(FRAME_LEN) + 1;
    logic [CW-1:0] beat_cnt;
    logic          at_end;
    logic          err_q;

    assign at_end     = (beat_cnt == CW'(FRAME_LEN - 1));
    assign force_last = xfer && at_end && !xfer_last;
    assign err_set    = xfer && ((xfer_last && !at_end) || force_last);
    assign err_len    = err_q;

    // The counter is zero whenever a grant starts because IDLE always precedes a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= err_set;
            if (state == IDLE) begin
                beat_cnt <= '0;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end
`else
    assign force_last = 1'b0;
    assign err_set    = 1'b0;
    assign err_len    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_srv <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_srv <= last_srv_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        last_srv_nxt = last_srv;
        s0_ready     = 1'b0;
        s1_ready     = 1'b0;
        case (state)
            IDLE: begin
                if (s0_valid && s1_valid) begin
                    state_nxt = last_srv ? RUN0 : RUN1;
                end else if (s0_valid) begin
                    state_nxt = RUN0;
                end else if (s1_valid) begin
                    state_nxt = RUN1;
                end
            end
            RUN0, RUN1: begin
                s0_ready = (state == RUN0);
                s1_ready = (state == RUN1);
                if (frame_end) begin
                    state_nxt    = IDLE;
                    last_srv_nxt = xfer_chan;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The channel tag rides alongside each beat so results can be attributed after log_scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ls_mag_squared <= '0;
            ls_mag_valid   <= 1'b0;
            ls_mag_last    <= 1'b0;
            ls_chan        <= 1'b0;
            tag_v          <= '0;
            tag_c          <= '0;
            m_log          <= '0;
            m_valid        <= 1'b0;
            m_last         <= 1'b0;
            m_chan         <= 1'b0;
        end else begin
            ls_mag_valid <= xfer;
            ls_mag_last  <= frame_end;
            if (xfer) begin
                ls_mag_squared <= xfer_mag;
                ls_chan        <= xfer_chan;
            end
            tag_v[0] <= ls_mag_valid;
            tag_c[0] <= ls_chan;
            for (int i = 1; i < LS_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_c[i] <= tag_c[i-1];
            end
            m_log   <= ls_log_out;
            m_valid <= ls_log_valid;
            m_last  <= ls_log_valid && ls_log_last;
            m_chan  <= tag_v[LS_LAT-1] && tag_c[LS_LAT-1];
        end
    end

    assign busy = (state != IDLE) || ls_mag_valid || (|tag_v);

endmodule
